// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter-width helper used to size the bit counter.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Ceiling log2, floored at 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/response bundle for the serial subtractor (start/done handshake).
// The overflow signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             borrowin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             borrowout;
`ifdef SERIAL_SUB_OVF_EN
    logic             overflow;

    modport master (
        output start, minuend, subtrahend, borrowin,
        input  busy, done, difference, borrowout, overflow
    );

    modport slave (
        input  start, minuend, subtrahend, borrowin,
        output busy, done, difference, borrowout, overflow
    );
`else
    modport master (
        output start, minuend, subtrahend, borrowin,
        input  busy, done, difference, borrowout
    );

    modport slave (
        input  start, minuend, subtrahend, borrowin,
        output busy, done, difference, borrowout
    );
`endif

endinterface

// File: rtl/serial_subtractor_fa.sv
// Single full-adder slice, reused every bit-cycle by the serial subtractor.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - borrowin: one full-adder slice with B inverted, run over WIDTH cycles.
// Optional signed overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);

    localparam int             CNT_W      = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic accept;
    logic lastBit;
    logic bInv;
    logic sumBit;
    logic carryOut;

    assign accept  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign lastBit = (state_q == ST_SHIFT) && (count_q == LAST_COUNT);
    assign bInv    = ~opB_q[0];

    full_adder_cell u_fa (
        .a    (opA_q[0]),
        .b    (bInv),
        .cin  (carry_q),
        .sum  (sumBit),
        .cout (carryOut)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
            ST_SHIFT: if (lastBit)   state_d = ST_DONE;
            ST_DONE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sum bits enter the top of the A register as its low bits are consumed, so after
    // WIDTH-1 shifts opA_q[WIDTH-1:1] holds the low result bits and opA_q[0] is A's sign.
    always_comb begin
        opA_d    = opA_q;
        opB_d    = opB_q;
        carry_d  = carry_q;
        count_d  = count_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            opA_d   = bus.minuend;
            opB_d   = bus.subtrahend;
            carry_d = ~bus.borrowin;
            count_d = '0;
        end else if (state_q == ST_SHIFT) begin
            opA_d   = {sumBit, opA_q[WIDTH-1:1]};
            opB_d   = {1'b0, opB_q[WIDTH-1:1]};
            carry_d = carryOut;
            count_d = count_q + 1'b1;
            if (lastBit) begin
                diff_d   = {sumBit, opA_q[WIDTH-1:1]};
                borrow_d = ~carryOut;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d    = (opA_q[0] != opB_q[0]) && (sumBit != opA_q[0]);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opA_q    <= '0;
            opB_q    <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.difference = diff_q;
    assign bus.borrowout  = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of the WIDTH=4 serial subtractor.
// Overflow checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one request in the current cycle and returns how many cycles later done rose
    // (-1 if it never did within the bound); on return the bench sits in the done cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin, output int lat);
        bus.start      = 1'b1;
        bus.minuend    = a;
        bus.subtrahend = b;
        bus.borrowin   = bin;
        tick();
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; (i <= WIDTH + 3) && (lat < 0); i++) begin
            if (bus.done) begin
                lat = i;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        int          lat;
        int          doneCount;
        int          doneMask;
        logic [4:0]  refVal;
        logic [3:0]  av;
        logic [3:0]  bv;
        checks = 0;
        errors = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.minuend    = '0;
        bus.subtrahend = '0;
        bus.borrowin   = 1'b0;
        tick();
        tick();

        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset diff", 32'(bus.difference), 32'd0);
        checkOutput("reset bout", 32'(bus.borrowout), 32'd0);
        checkOutput("reset state", 32'(dut.state_q), 32'(ST_IDLE));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("reset ovf", 32'(bus.overflow), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // 5 - 3 with a cycle-by-cycle busy/done trace
        bus.start      = 1'b1;
        bus.minuend    = 4'd5;
        bus.subtrahend = 4'd3;
        bus.borrowin   = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("trace busy c%0d", c), 32'(bus.busy), 32'd1);
            checkOutput($sformatf("trace done c%0d", c), 32'(bus.done), 32'd0);
            tick();
        end
        checkOutput("trace done c5", 32'(bus.done), 32'd1);
        checkOutput("trace busy c5", 32'(bus.busy), 32'd0);
        checkOutput("5-3 diff", 32'(bus.difference), 32'd2);
        checkOutput("5-3 bout", 32'(bus.borrowout), 32'd0);
        tick();
        checkOutput("trace done c6", 32'(bus.done), 32'd0);
        checkOutput("5-3 diff held", 32'(bus.difference), 32'd2);

        // start held high for 10 cycles: 9 - 4 twice, done at cycles 5 and 10
        bus.start      = 1'b1;
        bus.minuend    = 4'd9;
        bus.subtrahend = 4'd4;
        bus.borrowin   = 1'b0;
        doneCount = 0;
        doneMask  = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 10) bus.start = 1'b0;
            if (bus.done) begin
                doneCount++;
                doneMask = doneMask | (1 << c);
            end
            if (c == 10) checkOutput("b2b diff", 32'(bus.difference), 32'd5);
        end
        checkOutput("b2b done count", 32'(doneCount), 32'd2);
        checkOutput("b2b done cycles", 32'(doneMask), 32'h0420);

        // start pulse and operand changes while busy are ignored
        bus.start      = 1'b1;
        bus.minuend    = 4'd6;
        bus.subtrahend = 4'd2;
        bus.borrowin   = 1'b0;
        doneCount = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            bus.start = (c == 2);
            if (c == 2) begin
                bus.minuend    = 4'd0;
                bus.subtrahend = 4'd15;
                bus.borrowin   = 1'b1;
            end
            if (bus.done) doneCount++;
        end
        checkOutput("busy pulse done count", 32'(doneCount), 32'd1);
        checkOutput("busy pulse diff", 32'(bus.difference), 32'd4);
        checkOutput("busy pulse bout", 32'(bus.borrowout), 32'd0);

        // directed vectors, issued back to back through DONE -> SHIFT
        applyStimulus(4'd3, 4'd5, 1'b0, lat);
        checkOutput("3-5 latency", 32'(lat), 32'd5);
        checkOutput("3-5 diff", 32'(bus.difference), 32'hE);
        checkOutput("3-5 bout", 32'(bus.borrowout), 32'd1);
        applyStimulus(4'd0, 4'd0, 1'b1, lat);
        checkOutput("0-0-1 latency", 32'(lat), 32'd5);
        checkOutput("0-0-1 diff", 32'(bus.difference), 32'hF);
        checkOutput("0-0-1 bout", 32'(bus.borrowout), 32'd1);
        applyStimulus(4'd0, 4'd1, 1'b0, lat);
        checkOutput("0-1 diff", 32'(bus.difference), 32'hF);
        checkOutput("0-1 bout", 32'(bus.borrowout), 32'd1);
        applyStimulus(4'd0, 4'd15, 1'b1, lat);
        checkOutput("0-15-1 diff", 32'(bus.difference), 32'h0);
        checkOutput("0-15-1 bout", 32'(bus.borrowout), 32'd1);
        applyStimulus(4'd15, 4'd15, 1'b0, lat);
        checkOutput("15-15 diff", 32'(bus.difference), 32'h0);
        checkOutput("15-15 bout", 32'(bus.borrowout), 32'd0);
        applyStimulus(4'd15, 4'd0, 1'b1, lat);
        checkOutput("15-0-1 diff", 32'(bus.difference), 32'hE);
        checkOutput("15-0-1 bout", 32'(bus.borrowout), 32'd0);
        tick();

        // reset in cycle 2 of an operation aborts it
        bus.start      = 1'b1;
        bus.minuend    = 4'd7;
        bus.subtrahend = 4'd1;
        bus.borrowin   = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkOutput("abort diff", 32'(bus.difference), 32'd0);
        checkOutput("abort bout", 32'(bus.borrowout), 32'd0);
        checkOutput("abort state", 32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        doneCount = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.done) doneCount++;
        end
        checkOutput("abort no done", 32'(doneCount), 32'd0);
        applyStimulus(4'd12, 4'd5, 1'b1, lat);
        checkOutput("post-abort latency", 32'(lat), 32'd5);
        checkOutput("post-abort diff", 32'(bus.difference), 32'd6);
        checkOutput("post-abort bout", 32'(bus.borrowout), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
        applyStimulus(4'h8, 4'h1, 1'b0, lat);
        checkOutput("8-1 diff", 32'(bus.difference), 32'h7);
        checkOutput("8-1 ovf", 32'(bus.overflow), 32'd1);
        applyStimulus(4'h7, 4'h1, 1'b0, lat);
        checkOutput("7-1 diff", 32'(bus.difference), 32'h6);
        checkOutput("7-1 ovf", 32'(bus.overflow), 32'd0);
`endif

        // every (A, B, borrowin) against the wide-subtraction reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bin = 0; bin < 2; bin++) begin
                    av = 4'(a);
                    bv = 4'(b);
                    refVal = {1'b0, av} - {1'b0, bv} - 5'(bin);
                    applyStimulus(av, bv, 1'(bin), lat);
                    checkOutput($sformatf("exh a=%0d b=%0d bin=%0d", a, b, bin),
                                {24'd0, lat[2:0], bus.borrowout, bus.difference},
                                {24'd0, 3'd5, refVal});
`ifdef SERIAL_SUB_OVF_EN
                    checkOutput($sformatf("exh ovf a=%0d b=%0d bin=%0d", a, b, bin),
                                32'(bus.overflow),
                                32'((av[3] != bv[3]) && (refVal[3] != av[3])));
`endif
                end
            end
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
